// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch/pipeline definitions: widths, NOP encoding, fetch state codes
package fetch_stage_pkg;

    localparam int          PC_W_DEF    = 64;
    localparam int          INSTR_W_DEF = 32;
    localparam logic [31:0] NOP_ENC     = 32'hD503201F;

    localparam logic [0:0]  ST_BOOT     = 1'b0;
    localparam logic [0:0]  ST_FETCH    = 1'b1;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with async reset, hold and flush
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);

    // Flush wins over hold so a redirect clears IF/ID even while decode is stalled;
    // a flushed slot keeps its old pc since nothing downstream looks at it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!hold) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, next-PC selection, imem handshake, IF/ID fill
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [PC_W-1:0]    startpc,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    currentpc,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    logic [0:0]      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic            fetching;
    logic            ifid_hold;
    logic            ifid_flush;

    assign fetching  = (state == ST_FETCH);
    assign pc_plus4  = pc + PC_W'(4);
    assign imem_req  = fetching && !reset;
    assign imem_addr = pc;
    assign currentpc = pc;

    // BOOT leaves one quiet cycle after reset; FETCH is the only steady state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc    <= startpc & ALIGN_MASK;
            state <= ST_BOOT;
        end else if (state == ST_BOOT) begin
            state <= ST_FETCH;
        end else if (branch_taken) begin
            pc <= branch_target & ALIGN_MASK;
        end else if (!stall && imem_ready) begin
            pc <= pc_plus4;
        end
    end

    // A stalled fetch drops the returned word; memory is stateless so it is simply refetched.
    assign ifid_flush = fetching && (branch_taken || (!stall && !imem_ready));
    assign ifid_hold  = !fetching || stall;

    if_id_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .CLK      (CLK),
        .reset    (reset),
        .hold     (ifid_hold),
        .flush    (ifid_flush),
        .pc_in    (pc),
        .instr_in (imem_data),
        .pc       (if_id_pc),
        .instr    (if_id_instr),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        CLK = 1'b0;
    logic        reset;
    logic [63:0] startpc;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [63:0] currentpc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the architectural fetch state.
    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_boot;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0F0F_1234;
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_stage dut (
        .CLK           (CLK),
        .reset         (reset),
        .startpc       (startpc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .currentpc     (currentpc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid)
    );

    task automatic model_reset(input logic [63:0] spc);
        m_pc    = {spc[63:2], 2'b00};
        m_ifpc  = 64'd0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_boot  = 1'b1;
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, sample #1 after the edge.
    task automatic step(input logic st, input logic br, input logic [63:0] tgt, input logic rdy);
        stall = st; branch_taken = br; branch_target = tgt; imem_ready = rdy;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (br) begin
            m_pc = {tgt[63:2], 2'b00};
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (st) begin
            // everything holds
        end else if (rdy) begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
        end else begin
            m_valid = 1'b0;
            m_instr = NOP;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] spc);
        reset = 1'b1; startpc = spc;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
        model_reset(spc);
        @(posedge CLK); #1;
        @(negedge CLK);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset(64'h103);
        vectors++;
        if (imem_req !== 1'b0 || currentpc !== 64'h100 || if_id_valid !== 1'b0 ||
            if_id_instr !== NOP || if_id_pc !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: req=%b pc=%h valid=%b instr=%h ifpc=%h want req=0 pc=100 valid=0 instr=%h ifpc=0",
                     imem_req, currentpc, if_id_valid, if_id_instr, if_id_pc, NOP);
        end
    endtask

    task automatic test_stream;
        do_reset(64'h100);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++; $display("FAIL boot_req: got %b want 0", imem_req);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (imem_req !== 1'b1 || if_id_valid !== 1'b0 || currentpc !== 64'h100 || imem_addr !== 64'h100) begin
            miscompares++;
            $display("FAIL edge1_boot: req=%b valid=%b pc=%h addr=%h want 1 0 100 100", imem_req, if_id_valid, currentpc, imem_addr);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (if_id_pc !== 64'h100 || if_id_valid !== 1'b1 || if_id_instr !== mem_word(64'h100)) begin
            miscompares++;
            $display("FAIL edge2_capture: ifpc=%h valid=%b instr=%h want 100 1 %h", if_id_pc, if_id_valid, if_id_instr, mem_word(64'h100));
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        vectors++;
        if (currentpc !== 64'h10C || if_id_pc !== 64'h108) begin
            miscompares++;
            $display("FAIL edge4_stream: pc=%h ifpc=%h want 10c 108", currentpc, if_id_pc);
        end
    endtask

    task automatic test_stall;
        do_reset(64'h100);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            vectors++;
            if (currentpc !== 64'h108 || if_id_pc !== 64'h104 || if_id_valid !== 1'b1 ||
                if_id_instr !== mem_word(64'h104)) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: pc=%h ifpc=%h valid=%b instr=%h want 108 104 1 %h",
                         i, currentpc, if_id_pc, if_id_valid, if_id_instr, mem_word(64'h104));
            end
        end
        step(0, 0, 0, 1);
        vectors++;
        if (if_id_pc !== 64'h108 || currentpc !== 64'h10C) begin
            miscompares++;
            $display("FAIL stall_release: ifpc=%h pc=%h want 108 10c", if_id_pc, currentpc);
        end
    endtask

    task automatic test_branch;
        step(1, 1, 64'h203, 1);
        vectors++;
        if (currentpc !== 64'h200 || if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr[1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL branch_over_stall: pc=%h valid=%b instr=%h want 200 0 %h", currentpc, if_id_valid, if_id_instr, NOP);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (if_id_pc !== 64'h200 || if_id_valid !== 1'b1 || currentpc !== 64'h204) begin
            miscompares++;
            $display("FAIL branch_target_fetch: ifpc=%h valid=%b pc=%h want 200 1 204", if_id_pc, if_id_valid, currentpc);
        end
    endtask

    task automatic test_bubble;
        do_reset(64'h40);
        step(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0);
            vectors++;
            if (if_id_valid !== 1'b0 || if_id_instr !== NOP || currentpc !== 64'h40) begin
                miscompares++;
                $display("FAIL bubble[%0d]: valid=%b instr=%h pc=%h want 0 %h 40", i, if_id_valid, if_id_instr, currentpc, NOP);
            end
        end
        step(0, 0, 0, 1);
        vectors++;
        if (if_id_pc !== 64'h40 || currentpc !== 64'h44 || if_id_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bubble_resume: ifpc=%h pc=%h valid=%b want 40 44 1", if_id_pc, currentpc, if_id_valid);
        end
    endtask

    task automatic test_wrap;
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        vectors++;
        if (currentpc !== 64'd0 || if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            miscompares++;
            $display("FAIL pc_wrap: pc=%h ifpc=%h want 0 fffffffffffffffc", currentpc, if_id_pc);
        end
    endtask

    task automatic test_async_reset;
        do_reset(64'h500);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #2;
        startpc = 64'h3000;
        reset = 1'b1;
        model_reset(64'h3000);
        #1;
        vectors++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || currentpc !== 64'h3000 || if_id_instr !== NOP) begin
            miscompares++;
            $display("FAIL async_reset: req=%b valid=%b pc=%h instr=%h want 0 0 3000 %h", imem_req, if_id_valid, currentpc, if_id_instr, NOP);
        end
        @(posedge CLK); #1;
        vectors++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || currentpc !== 64'h3000) begin
            miscompares++;
            $display("FAIL reset_held_edge: req=%b valid=%b pc=%h want 0 0 3000", imem_req, if_id_valid, currentpc);
        end
        @(negedge CLK);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_random;
        logic        st, br, rdy;
        logic [63:0] tgt;
        do_reset({$urandom, $urandom});
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = {$urandom, $urandom};
            step(st, br, tgt, rdy);
            vectors++;
            if (currentpc !== m_pc || if_id_pc !== m_ifpc || if_id_instr !== m_instr ||
                if_id_valid !== m_valid || imem_req !== 1'b1 || imem_addr !== m_pc) begin
                miscompares++;
                $display("FAIL random[%0d]: pc=%h ifpc=%h instr=%h valid=%b req=%b want pc=%h ifpc=%h instr=%h valid=%b req=1",
                         i, currentpc, if_id_pc, if_id_instr, if_id_valid, imem_req, m_pc, m_ifpc, m_instr, m_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1; startpc = '0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_ready = 1'b0;
        model_reset(64'd0);
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_bubble();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
